aes_dram_round_sched: RTL and testbench

- Round sequencer for the DRAM compute-in-memory AES engine.
- The DRAM array performs AddRoundKey and SubBytes. FPGA logic performs ShiftRows and MixColumns.
- This block orders each round's phases: write state into DRAM, CIM compute, read back, FPGA round logic. It also counts rounds and issues the final AddRoundKey-only pass.
- It sits between the top-level start/done handshake and the DRAM pin driver / FPGA round datapath.

---
 rtl/aes_dram_round_sched.sv | 138 +++++++++++++
 tb/tb_aes_dram_round_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dram_round_sched.sv
// Round sequencer for the DRAM compute-in-memory AES engine: WRITE -> CIM -> READ -> FPGA per round.
// Optional macro AES_SCHED_TRIGGER_EN adds a scope trigger on the round-0 compute window.
module aes_dram_round_sched #(
  parameter int NR      = 10,
  parameter int WR_CYC  = 4,
  parameter int CIM_LAT = 8,
  parameter int RD_CYC  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] round_idx,
  output logic       dram_wren,
  output logic       dram_cimen,
  output logic       dram_sbox_en,
  output logic       dram_rden,
  output logic       lane_capture,
  output logic       fpga_go,
  output logic       fpga_last,
  input  logic       fpga_done,
  output logic       trigger,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_CIM   = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_FPGA  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [7:0] WR_LAST  = 8'(WR_CYC - 1);
  localparam logic [7:0] CIM_LAST = 8'(CIM_LAT - 1);
  localparam logic [7:0] RD_LAST  = 8'(RD_CYC - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT);
  localparam logic [3:0] NR_L     = 4'(NR);
  localparam logic [3:0] NR_M1    = 4'(NR - 1);

  logic [2:0] state;
  logic [7:0] cnt;

  // Handshakes: start is taken only while idle (ignored otherwise, even if held);
  // done is a single-cycle pulse; fpga_go pulses once per round and fpga_done
  // counts only from the cycle after fpga_go until TIMEOUT cycles have passed.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      round_idx <= 4'd0;
      err       <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      round_idx <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_WRITE;
            cnt       <= 8'd0;
            round_idx <= 4'd0;
            err       <= 1'b0;
          end
        end
        S_WRITE: begin
          if (cnt == WR_LAST) begin
            state <= S_CIM;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_CIM: begin
          if (cnt == CIM_LAST) begin
            state <= S_READ;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_READ: begin
          if (cnt == RD_LAST) begin
            state <= (round_idx == NR_L) ? S_DONE : S_FPGA;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_FPGA: begin
          // cnt==0 is the fpga_go cycle, so a coincident fpga_done is not counted
          if (cnt != 8'd0 && fpga_done) begin
            state     <= S_WRITE;
            cnt       <= 8'd0;
            round_idx <= round_idx + 4'd1;
          end else if (cnt == TO_LAST) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= 8'd0;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Every output is a decode of registered state, so all read 0 while in reset.
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign dram_wren    = (state == S_WRITE);
  assign dram_cimen   = (state == S_CIM);
  assign dram_rden    = (state == S_READ);
  assign dram_sbox_en = (dram_wren | dram_cimen | dram_rden) && (round_idx != NR_L);
  assign lane_capture = dram_rden && (cnt == RD_LAST);
  assign fpga_go      = (state == S_FPGA) && (cnt == 8'd0);
  assign fpga_last    = fpga_go && (round_idx == NR_M1);
  assign state_dbg    = state;

`ifdef AES_SCHED_TRIGGER_EN
  assign trigger = dram_cimen && (round_idx == 4'd0);
`else
  assign trigger = 1'b0;
`endif

endmodule

// File: tb/tb_aes_dram_round_sched.sv
// Bench for aes_dram_round_sched: vector table of whole runs, a cycle-level
// reference trace with random latencies/aborts, and directed reset cases.
module tb_aes_dram_round_sched;

  localparam int NR_T  = 10;
  localparam int WR_T  = 4;
  localparam int CIM_T = 8;
  localparam int RD_T  = 4;
  localparam int TO_T  = 255;
`ifdef AES_SCHED_TRIGGER_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start, abort, fpga_done;
  logic       busy, done, err, dram_wren, dram_cimen, dram_sbox_en, dram_rden;
  logic       lane_capture, fpga_go, fpga_last, trigger;
  logic [3:0] round_idx;
  logic [2:0] state_dbg;

  aes_dram_round_sched dut (
    .CLK(clk), .RSTn(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err), .round_idx(round_idx),
    .dram_wren(dram_wren), .dram_cimen(dram_cimen), .dram_sbox_en(dram_sbox_en),
    .dram_rden(dram_rden), .lane_capture(lane_capture), .fpga_go(fpga_go),
    .fpga_last(fpga_last), .fpga_done(fpga_done), .trigger(trigger),
    .state_dbg(state_dbg)
  );

  int total = 0;
  int bad   = 0;

  // scoreboard: one entry per cycle (inputs to drive, expected outputs, care mask)
  logic [14:0] exp_q[$];
  logic [14:0] mask_q[$];
  logic [2:0]  st_q[$];

  // reference model state
  int         m_cyc, m_abort_at;
  bit         m_ab, m_noise, m_err, m_rknown;
  logic [3:0] m_round;

  // vector run results
  int r_done, r_idle, r_caps, r_lasts, r_gos, r_sb0, r_trig, r_dones;
  bit r_err;

  typedef struct {
    int lat;
    bit hold;
    int exp_done;
    int exp_idle;
    bit exp_err;
    int exp_caps;
    int exp_lasts;
    int exp_gos;
    int exp_sb0;
    int exp_trig;
    int exp_dones;
  } vec_t;

  vec_t vt[4];

  function automatic logic [14:0] obs();
    return {trigger, busy, done, err, round_idx, dram_wren, dram_cimen,
            dram_sbox_en, dram_rden, lane_capture, fpga_go, fpga_last};
  endfunction

  function automatic logic [14:0] mk(input bit trig, input bit bsy, input bit dn,
                                     input bit er, input logic [3:0] rd,
                                     input bit wr, input bit cim, input bit sb,
                                     input bit rdn, input bit cap, input bit go,
                                     input bit last);
    return {trig, bsy, dn, er, rd, wr, cim, sb, rdn, cap, go, last};
  endfunction

  function automatic bit rn();
    return m_noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) begin
      st_q.push_back(3'b000);
      exp_q.push_back(mk(0, 0, 0, m_err, m_round, 0, 0, 0, 0, 0, 0, 0));
      mask_q.push_back(m_rknown ? 15'h7FFF : 15'h787F);
    end
  endtask

  task automatic emit(input bit fd, input logic [14:0] e);
    bit a;
    if (m_ab) return;
    a = (m_cyc == m_abort_at);
    st_q.push_back({rn(), a, fd});
    exp_q.push_back(e);
    mask_q.push_back(15'h7FFF);
    m_cyc++;
    if (a) begin
      m_ab     = 1'b1;
      m_round  = 4'd0;
      m_rknown = 1'b1;
    end
  endtask

  // One encryption request: start cycle, then NR+1 DRAM passes with NR FPGA
  // rounds between them. lat[r] = cycles from fpga_go to fpga_done (<=0: never).
  task automatic plan_encrypt(input int lat[NR_T], input int abort_at, input bit noise);
    logic [3:0] r4;
    int l, kmax;
    st_q.push_back(3'b100);
    exp_q.push_back(mk(0, 0, 0, m_err, m_round, 0, 0, 0, 0, 0, 0, 0));
    mask_q.push_back(m_rknown ? 15'h7FFF : 15'h787F);
    m_err = 1'b0; m_cyc = 0; m_ab = 1'b0; m_abort_at = abort_at; m_noise = noise;
    for (int r = 0; r <= NR_T; r++) begin
      r4 = 4'(r);
      for (int k = 0; k < WR_T; k++)
        emit(rn(), mk(0, 1, 0, 0, r4, 1, 0, r < NR_T, 0, 0, 0, 0));
      for (int k = 0; k < CIM_T; k++)
        emit(rn(), mk(TRIG && r == 0, 1, 0, 0, r4, 0, 1, r < NR_T, 0, 0, 0, 0));
      for (int k = 0; k < RD_T; k++)
        emit(rn(), mk(0, 1, 0, 0, r4, 0, 0, r < NR_T, 1, k == RD_T - 1, 0, 0));
      if (r == NR_T) begin
        emit(rn(), mk(0, 1, 1, 0, r4, 0, 0, 0, 0, 0, 0, 0));
        if (!m_ab) begin
          m_round  = r4;
          m_rknown = 1'b1;
        end
      end else begin
        l    = lat[r];
        kmax = (l > 0 && l <= TO_T) ? l : TO_T;
        for (int k = 0; k <= kmax; k++)
          emit((k == 0) ? rn() : (k == l),
               mk(0, 1, 0, 0, r4, 0, 0, 0, 0, 0, k == 0, k == 0 && r == NR_T - 1));
        if (l <= 0 || l > TO_T) begin
          if (!m_ab) begin
            m_err    = 1'b1;
            m_rknown = 1'b0;
          end
          m_ab = 1'b1;
        end
      end
    end
  endtask

  task automatic run_trace();
    logic [14:0] e, m, a;
    logic [2:0]  s;
    int step;
    step = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      s = st_q.pop_front();
      @(posedge clk); #1;
      {start, abort, fpga_done} = s;
      @(negedge clk);
      a = obs();
      total++;
      if ((a & m) !== (e & m)) begin
        bad++;
        $display("FAIL trace step=%0d act=%h exp=%h mask=%h", step, a, e, m);
      end
      step++;
    end
    start = 1'b0; abort = 1'b0; fpga_done = 1'b0;
  endtask

  // Whole-run measurement with a reactive fpga_done responder.
  task automatic run_vec(input int lat, input bit hold);
    int due;
    bit held;
    r_done = -1; r_idle = -1; r_caps = 0; r_lasts = 0; r_gos = 0;
    r_sb0 = 0; r_trig = 0; r_dones = 0; r_err = 1'b0;
    due = -1; held = hold;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; fpga_done = 1'b0;
    @(negedge clk);
    for (int c = 1; c < 600 && r_idle < 0; c++) begin
      @(posedge clk); #1;
      start     = held;
      fpga_done = (c == due);
      @(negedge clk);
      if (done) begin r_done = c; r_dones++; held = 1'b0; end
      if (fpga_go) begin r_gos++; if (lat > 0) due = c + lat; end
      if (fpga_last) r_lasts++;
      if (lane_capture) r_caps++;
      if ((dram_wren | dram_cimen | dram_rden) && !dram_sbox_en) r_sb0++;
      if (trigger) r_trig++;
      if (!busy) begin r_idle = c; r_err = err; end
    end
    start = 1'b0; fpga_done = 1'b0;
  endtask

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat[NR_T];
    int tr;
    tr = TRIG ? 8 : 0;
    vt[0] = '{3,  1'b1, 217, 218, 1'b0, 11, 1, 10, 16, tr, 1};
    vt[1] = '{0,  1'b0, -1,  273, 1'b1, 1,  0, 1,  0,  tr, 0};
    vt[2] = '{1,  1'b0, 197, 198, 1'b0, 11, 1, 10, 16, tr, 1};
    vt[3] = '{10, 1'b1, 287, 288, 1'b0, 11, 1, 10, 16, tr, 1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; fpga_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", int'(obs()), 0);
    check("reset_state", int'(state_dbg), 0);

    for (int i = 0; i < 4; i++) begin
      run_vec(vt[i].lat, vt[i].hold);
      check($sformatf("v%0d_done_cycle", i), r_done, vt[i].exp_done);
      check($sformatf("v%0d_idle_cycle", i), r_idle, vt[i].exp_idle);
      check($sformatf("v%0d_err", i), int'(r_err), int'(vt[i].exp_err));
      check($sformatf("v%0d_captures", i), r_caps, vt[i].exp_caps);
      check($sformatf("v%0d_fpga_last", i), r_lasts, vt[i].exp_lasts);
      check($sformatf("v%0d_fpga_go", i), r_gos, vt[i].exp_gos);
      check($sformatf("v%0d_ark_only", i), r_sb0, vt[i].exp_sb0);
      check($sformatf("v%0d_trigger", i), r_trig, vt[i].exp_trig);
      check($sformatf("v%0d_done_count", i), r_dones, vt[i].exp_dones);
    end

    // abort in round-4 compute, then a clean run started two cycles later
    m_err = 1'b0; m_round = 4'(NR_T); m_rknown = 1'b1;
    foreach (lat[j]) lat[j] = 3;
    plan_encrypt(lat, 4 * 20 + WR_T + 2, 1'b0);
    push_idle(1);
    plan_encrypt(lat, -1, 1'b0);
    push_idle(2);
    run_trace();

    // random latencies, occasional timeouts and aborts, noisy start/fpga_done
    for (int it = 0; it < 6; it++) begin
      foreach (lat[j]) lat[j] = $urandom_range(1, 5);
      if ($urandom_range(0, 3) == 0) lat[$urandom_range(0, NR_T - 1)] = 0;
      plan_encrypt(lat, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 240)) : -1, 1'b1);
      push_idle($urandom_range(1, 3));
      run_trace();
    end

    // asynchronous reset clears a sticky err without a clock edge
    run_vec(0, 1'b0);
    check("timeout_err_set", int'(err), 1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_clears_err", int'(err), 0);
    check("reset_idle_outputs", int'(obs()), 0);
    @(negedge clk) rst_n = 1'b1;

    // asynchronous reset in the middle of the round-0 read phase
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
    end
    check("pre_reset_read", int'(dram_rden), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'(obs()), 0);
    check("async_reset_state", int'(state_dbg), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", int'(obs()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
